// File: rtl/i2c_apb_cmd_bridge.sv
// ============================================================================
// i2c_apb_cmd_bridge : APB3 registers + TX FIFO + byte issue sequencer for the I2C actuator
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_apb_cmd_bridge #(
   parameter int FIFO_DEPTH     = 4,
   parameter int DV_HOLD        = 4,
   parameter int ACCEPT_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [3:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [6:0]  o_taaddr6_0,
   output logic [7:0]  o_wdata,
   output logic        o_write,
   output logic        o_apb_dv,
   input  logic        i_rdbsybar,
   input  logic        i_i2c_err,
   output logic        o_irq
);

   localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_L   = 5'(FIFO_DEPTH);
   localparam logic [7:0]  HOLD_LAST = 8'(DV_HOLD - 1);
   localparam logic [15:0] TO_LAST   = 16'(ACCEPT_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_HOLD   = 3'd2,
      S_ACCEPT = 3'd3,
      S_XFER   = 3'd4
   } state_t;

   state_t        state, state_nx;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [4:0]    level;
   logic          full, empty, busy;
   logic [6:0]    addr_reg;
   logic          irq_en_done, irq_en_err;
   logic          done, err, timeout;
   logic [7:0]    dv_cnt;
   logic [15:0]   to_cnt;

   logic          wr_acc, rd_acc;
   logic [1:0]    sel;
   logic          wr_addr, wr_tx, wr_ctrl, wr_stat;
   logic          err_tx, err_addr, err_start;
   logic          push, ctrl_ok, start_go, flush_go;
   logic          pop, abort, set_done, set_to, set_err;
   logic          unused_bits;

   assign full  = (level == DEPTH_L);
   assign empty = (level == 5'd0);
   assign busy  = (state != S_IDLE);

   assign wr_acc  = psel & penable & pwrite;
   assign rd_acc  = psel & penable & ~pwrite;
   assign sel     = paddr[3:2];
   assign wr_addr = wr_acc & (sel == 2'd0);
   assign wr_tx   = wr_acc & (sel == 2'd1);
   assign wr_ctrl = wr_acc & (sel == 2'd2);
   assign wr_stat = wr_acc & (sel == 2'd3);

   // Rejected accesses have no side effects at all
   assign err_tx    = wr_tx & full;
   assign err_addr  = wr_addr & busy;
   assign err_start = wr_ctrl & pwdata[0] & empty;
   assign pslverr   = err_tx | err_addr | err_start;
   assign pready    = 1'b1;

   assign push     = wr_tx & ~full;
   assign ctrl_ok  = wr_ctrl & ~err_start;
   assign start_go = ctrl_ok & pwdata[0] & ~busy;
   assign flush_go = ctrl_ok & pwdata[1] & ~busy & ~start_go;
   assign set_err  = i_i2c_err | set_to;

   assign unused_bits = ^{pwdata[31:8], paddr[1:0]};

   always_comb begin
      prdata = '0;
      if (rd_acc) begin
         case (sel)
            2'd0:    prdata[6:0] = addr_reg;
            2'd2:    prdata[3:2] = {irq_en_err, irq_en_done};
            2'd3:    prdata = {19'd0, level, 2'd0, empty, full, timeout, err, done, busy};
            default: prdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      abort    = 1'b0;
      set_done = 1'b0;
      set_to   = 1'b0;
      o_apb_dv = 1'b0;
      o_write  = 1'b0;
      case (state)
         S_IDLE: if (start_go) state_nx = S_LOAD;
         S_LOAD: begin
            o_write = 1'b1;
            if (i_rdbsybar) begin
               pop      = 1'b1;
               state_nx = S_HOLD;
            end
         end
         S_HOLD: begin
            o_write  = 1'b1;
            o_apb_dv = 1'b1;
            if (dv_cnt == HOLD_LAST) state_nx = S_ACCEPT;
         end
         S_ACCEPT: begin
            if (!i_rdbsybar) begin
               state_nx = S_XFER;
            end else if (to_cnt == TO_LAST) begin
               set_to   = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_XFER: begin
            if (i_rdbsybar) begin
               if (!empty) begin
                  state_nx = S_LOAD;
               end else begin
                  set_done = 1'b1;
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // An actuator error overrides whatever the sequencer was about to do
      if (busy && i_i2c_err) begin
         abort    = 1'b1;
         pop      = 1'b0;
         set_done = 1'b0;
         set_to   = 1'b0;
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         o_wdata     <= '0;
         o_taaddr6_0 <= '0;
         addr_reg    <= '0;
         irq_en_done <= 1'b0;
         irq_en_err  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         timeout     <= 1'b0;
         o_irq       <= 1'b0;
         dv_cnt      <= '0;
         to_cnt      <= '0;
      end else begin
         if (abort || flush_go) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= pwdata[7:0];
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
               2'b10:   level <= level + 5'd1;
               2'b01:   level <= level - 5'd1;
               default: level <= level;
            endcase
         end
         if (pop)      o_wdata     <= mem[rd_ptr];
         if (start_go) o_taaddr6_0 <= addr_reg;
         if (wr_addr && !busy) addr_reg <= pwdata[6:0];
         if (ctrl_ok) begin
            irq_en_done <= pwdata[2];
            irq_en_err  <= pwdata[3];
         end
         // W1C clears lose against a same-cycle set
         done    <= set_done | (done    & ~(wr_stat & pwdata[1]));
         err     <= set_err  | (err     & ~(wr_stat & pwdata[2]));
         timeout <= set_to   | (timeout & ~(wr_stat & pwdata[3]));
         o_irq   <= (done & irq_en_done) | ((err | timeout) & irq_en_err);
         dv_cnt  <= (state == S_HOLD)   ? dv_cnt + 8'd1  : 8'd0;
         to_cnt  <= (state == S_ACCEPT) ? to_cnt + 16'd1 : 16'd0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_apb_cmd_bridge.sv
// ============================================================================
// tb_i2c_apb_cmd_bridge : self-checking bench with actuator model and byte-stream scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_i2c_apb_cmd_bridge;

   localparam int FIFO_DEPTH     = 4;
   localparam int DV_HOLD        = 4;
   localparam int ACCEPT_TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [3:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [6:0]  o_taaddr6_0;
   logic [7:0]  o_wdata;
   logic        o_write, o_apb_dv, o_irq;
   logic        i_rdbsybar = 1'b1;
   logic        i_i2c_err = 1'b0;

   i2c_apb_cmd_bridge #(
      .FIFO_DEPTH(FIFO_DEPTH), .DV_HOLD(DV_HOLD), .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .o_taaddr6_0(o_taaddr6_0), .o_wdata(o_wdata), .o_write(o_write), .o_apb_dv(o_apb_dv),
      .i_rdbsybar(i_rdbsybar), .i_i2c_err(i_i2c_err), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: bytes sitting in the FIFO, flags, programmed/latched address
   logic [7:0] fifo_q[$];
   logic       m_done = 1'b0, m_err = 1'b0, m_to = 1'b0;
   logic [6:0] m_addr = '0, m_taddr = '0;

   int  strobes = 0, last_rise = 0, last_fall = 0, irq_rise = 0, last_edge = 0;
   logic skip_dv = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic logic [31:0] m_status(input logic busy);
      int n;
      n = fifo_q.size();
      return {19'd0, 5'(n), 2'd0, (n == 0), (n == FIFO_DEPTH), m_to, m_err, m_done, busy};
   endfunction

   // Each strobe must carry the FIFO head, the latched address, last DV_HOLD cycles
   logic       in_pulse = 1'b0, prev_irq = 1'b0;
   int         plen = 0;
   logic [7:0] cur = '0;
   always @(negedge clk) begin
      if (rst || skip_dv) begin
         in_pulse = 1'b0;
      end else if (o_apb_dv) begin
         if (!in_pulse) begin
            in_pulse  = 1'b1;
            plen      = 0;
            strobes++;
            last_rise = cyc + 1;
            chk("dv_has_byte", 32'(fifo_q.size() != 0), 1);
            if (fifo_q.size() != 0) cur = fifo_q.pop_front();
         end
         plen++;
         chk("dv_wdata", o_wdata, cur);
         chk("dv_taddr", o_taaddr6_0, m_taddr);
         chk("dv_write", o_write, 1);
      end else if (in_pulse) begin
         in_pulse  = 1'b0;
         last_fall = cyc;
         chk("dv_len", plen, DV_HOLD);
      end
      if (o_irq && !prev_irq) irq_rise = cyc;
      prev_irq = o_irq;
   end

   // Actuator: goes busy for busy_len cycles after each strobe, optional NACK/no-response
   int   busy_len = 20, a_cnt = 0, a_idx = 0, nack_idx = -1;
   logic act_timeout = 1'b0, a_prev_dv = 1'b0;
   always @(negedge clk) begin
      i_i2c_err = 1'b0;
      if (rst || skip_dv) begin
         a_cnt = 0;
         i_rdbsybar = 1'b1;
      end else if (a_prev_dv && !o_apb_dv) begin
         a_idx++;
         if (!act_timeout) begin
            i_rdbsybar = 1'b0;
            a_cnt      = busy_len;
         end
      end else if (a_cnt > 0) begin
         a_cnt--;
         if (a_idx == nack_idx && a_cnt == busy_len / 2) i_i2c_err = 1'b1;
         if (a_cnt == 0) i_rdbsybar = 1'b1;
      end
      a_prev_dv = o_apb_dv;
   end

   task automatic apb_wr(input logic [3:0] a, input logic [31:0] d, output logic e);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      penable = 1'b1;
      #1 e = pslverr;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      last_edge = cyc;
   endtask

   task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata;
      @(posedge clk);
      #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic push(input logic [7:0] b, input string nm);
      logic e, exp_e;
      exp_e = (fifo_q.size() == FIFO_DEPTH);
      apb_wr(4'h4, {24'd0, b}, e);
      chk(nm, e, exp_e);
      if (!exp_e) fifo_q.push_back(b);
   endtask

   task automatic chk_status(input string nm, input logic busy, input logic [31:0] lit);
      logic [31:0] r;
      apb_rd(4'hC, r);
      chk(nm, r, m_status(busy));
      chk({nm, "_lit"}, r, lit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        e;
      logic [31:0] r;
      int          s0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      chk("rst_dv", o_apb_dv, 0);
      chk("rst_write", o_write, 0);
      chk("rst_irq", o_irq, 0);
      chk("rst_taddr", o_taaddr6_0, 0);
      chk("rst_pready", pready, 1);
      chk_status("rst_status", 1'b0, 32'h20);
      apb_rd(4'h0, r);  chk("rst_addr", r, 0);
      apb_rd(4'h4, r);  chk("txdata_reads_zero", r, 0);

      // 1: single byte, latency, DONE and irq
      apb_wr(4'h0, 32'h50, e); chk("t1_addr_err", e, 0); m_addr = 7'h50;
      push(8'hA5, "t1_push");
      busy_len = 20;
      m_taddr = m_addr;
      s0 = strobes;
      apb_wr(4'h8, 32'h5, e); chk("t1_start_err", e, 0);
      repeat (45) @(negedge clk);
      m_done = 1'b1;
      chk("t1_strobes", strobes - s0, 1);
      chk("t1_latency", last_rise - last_edge, 2);
      chk("t1_taddr", o_taaddr6_0, 7'h50);
      chk("t1_write_idle", o_write, 0);
      chk("t1_irq", o_irq, 1);
      chk_status("t1_status", 1'b0, 32'h22);
      apb_wr(4'hC, 32'h2, e); m_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("t1_irq_clr", o_irq, 0);

      // 2: FIFO full boundary and ordered issue
      busy_len = 6;
      push(8'h11, "t2_push1"); push(8'h22, "t2_push2");
      push(8'h33, "t2_push3"); push(8'h44, "t2_push4");
      chk_status("t2_full", 1'b0, 32'h410);
      push(8'h55, "t2_push_full_rejected");
      chk_status("t2_still_full", 1'b0, 32'h410);
      s0 = strobes;
      m_taddr = m_addr;
      apb_wr(4'h8, 32'h1, e); chk("t2_start_err", e, 0);
      repeat (100) @(negedge clk);
      m_done = 1'b1;
      chk("t2_strobes", strobes - s0, 4);
      chk_status("t2_done", 1'b0, 32'h22);
      apb_wr(4'hC, 32'h2, e); m_done = 1'b0;

      // 3: NACK during the second byte's transfer
      nack_idx = a_idx + 2;
      push(8'h01, "t3_push1"); push(8'h02, "t3_push2"); push(8'h03, "t3_push3");
      s0 = strobes;
      m_taddr = m_addr;
      apb_wr(4'h8, 32'h1, e); chk("t3_start_err", e, 0);
      repeat (60) @(negedge clk);
      fifo_q.delete();
      m_err = 1'b1;
      nack_idx = -1;
      chk("t3_strobes", strobes - s0, 2);
      chk("t3_irq_disabled", o_irq, 0);
      chk_status("t3_status", 1'b0, 32'h24);
      apb_wr(4'hC, 32'h4, e); m_err = 1'b0;

      // 4: actuator never goes busy -> timeout
      act_timeout = 1'b1;
      push(8'h77, "t4_push");
      m_taddr = m_addr;
      apb_wr(4'h8, 32'h9, e); chk("t4_start_err", e, 0);
      repeat (90) @(negedge clk);
      m_to = 1'b1; m_err = 1'b1;
      chk("t4_timeout_delay", irq_rise - last_fall, ACCEPT_TIMEOUT + 1);
      chk("t4_irq", o_irq, 1);
      chk_status("t4_status", 1'b0, 32'h2C);
      apb_wr(4'hC, 32'hC, e); m_to = 1'b0; m_err = 1'b0;
      chk_status("t4_cleared", 1'b0, 32'h20);
      chk("t4_irq_clr", o_irq, 0);
      act_timeout = 1'b0;

      // 5: illegal accesses
      apb_wr(4'h8, 32'h1, e); chk("t5_start_empty_err", e, 1);
      chk_status("t5_not_busy", 1'b0, 32'h20);
      push(8'h5A, "t5_push");
      m_taddr = m_addr;
      apb_wr(4'h8, 32'h1, e); chk("t5_start_err", e, 0);
      apb_wr(4'h0, 32'h33, e); chk("t5_addr_busy_err", e, 1);
      apb_rd(4'h0, r); chk("t5_addr_kept", r, 32'h50);
      repeat (40) @(negedge clk);
      m_done = 1'b1;
      chk("t5_taddr", o_taaddr6_0, 7'h50);
      chk_status("t5_done", 1'b0, 32'h22);

      // 6: reset while the strobe is high
      push(8'hC3, "t6_push1"); push(8'h3C, "t6_push2");
      m_taddr = m_addr;
      apb_wr(4'h8, 32'h5, e);
      for (int i = 0; i < 10 && !o_apb_dv; i++) @(negedge clk);
      chk("t6_dv_seen", o_apb_dv, 1);
      skip_dv = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t6_dv_dropped", o_apb_dv, 0);
      fifo_q.delete();
      m_done = 1'b0; m_err = 1'b0; m_to = 1'b0; m_addr = '0;
      @(negedge clk);
      #1 skip_dv = 1'b0;
      s0 = strobes;
      chk_status("t6_status", 1'b0, 32'h20);
      apb_rd(4'h0, r); chk("t6_addr", r, 0);
      repeat (10) @(negedge clk);
      chk("t6_idle_no_dv", strobes - s0, 0);
      chk("t6_taddr", o_taaddr6_0, 0);
      chk("t6_wdata", o_wdata, 0);
      chk("t6_irq", o_irq, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
